// File: rtl/fir_decim_fifo.sv
// fir_decim_fifo: warm-up skip, decimation and FWFT buffering of FIR output samples.
//
// state  | meaning
// -------+------------------------------------------------------------
// WARMUP | discarding the first SKIP valid samples while the filter fills
// RUN    | keeping every DECIM-th valid sample into the FIFO
module fir_decim_fifo #(
    parameter int DECIM = 4,
    parameter int SKIP  = 63,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_p,
    input  logic [15:0]              y_in,
    input  logic                     in_valid,
    output logic [15:0]              m_data,
    output logic                     m_valid,
    input  logic                     m_ready,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     overflow,
    input  logic                     clr_ovf
);

    localparam int AW = $clog2(DEPTH);
    localparam int WW = (SKIP > 1) ? $clog2(SKIP) : 1;
    localparam int PW = (DECIM > 1) ? $clog2(DECIM) : 1;
    localparam logic [WW-1:0] WU_LAST  = WW'((SKIP > 0) ? SKIP - 1 : 0);
    localparam logic [PW-1:0] PH_LAST  = PW'(DECIM - 1);
    localparam logic [AW:0]   LVL_FULL = (AW + 1)'(DEPTH);

    typedef enum logic {
        WARMUP = 1'b0,
        RUN    = 1'b1
    } state_t;

    // With no warm-up requested the block comes out of reset already running.
    localparam state_t RST_STATE = (SKIP == 0) ? RUN : WARMUP;

    state_t          state, state_nxt;
    logic [WW-1:0]   wu_cnt;
    logic [PW-1:0]   phase;
    logic            wu_inc, ph_adv, keep;
    logic [15:0]     mem [DEPTH];
    logic [AW-1:0]   wr_ptr, rd_ptr;
    logic            pop, push, drop, full;

    // State register.
    always_ff @(posedge clk or posedge rst_p) begin
        if (rst_p) state <= RST_STATE;
        else       state <= state_nxt;
    end

    // Leave warm-up on the cycle that consumes the last discarded sample.
    always_comb begin
        state_nxt = state;
        if (state == WARMUP && in_valid && wu_cnt == WU_LAST)
            state_nxt = RUN;
    end

    // Per-cycle strobes derived from the current state.
    always_comb begin
        wu_inc = 1'b0;
        ph_adv = 1'b0;
        keep   = 1'b0;
        if (in_valid) begin
            if (state == WARMUP) begin
                wu_inc = 1'b1;
            end else begin
                ph_adv = 1'b1;
                keep   = (phase == '0);
            end
        end
    end

    // Warm-up sample counter and decimation phase.
    always_ff @(posedge clk or posedge rst_p) begin
        if (rst_p) begin
            wu_cnt <= '0;
            phase  <= '0;
        end else begin
            if (wu_inc)
                wu_cnt <= wu_cnt + 1'b1;
            if (ph_adv)
                phase <= (phase == PH_LAST) ? '0 : phase + 1'b1;
        end
    end

    assign full    = (level == LVL_FULL);
    assign m_valid = (level != '0);
    assign pop     = m_valid && m_ready;
    // A pop in the same cycle frees the slot, so push at full is lossless.
    assign push    = keep && (!full || pop);
    assign drop    = keep && full && !pop;
    assign m_data  = mem[rd_ptr];

    // Sample storage; contents need no reset since level gates visibility.
    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= y_in;
    end

    // Pointers, occupancy and sticky overflow (set beats clear).
    always_ff @(posedge clk or posedge rst_p) begin
        if (rst_p) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            level    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
            if (drop)
                overflow <= 1'b1;
            else if (clr_ovf)
                overflow <= 1'b0;
        end
    end

endmodule

// File: doc/fir_decim_fifo.md
# fir_decim_fifo

Downstream stage of the 63-tap FIR filter block. Takes the filter's 16-bit `y_out` stream, one candidate sample per clock when qualified by `in_valid`, and discards the first `SKIP` samples while the filter delay line fills. It then keeps every `DECIM`-th sample and buffers kept samples in a first-word-fall-through FIFO. A valid/ready master port delivers the samples, and a sticky overflow flag reports dropped samples.

## Interface
- `DECIM`, default 4: decimation ratio, ≥1; 1 keeps every sample.
- `SKIP`, default 63: number of valid input samples discarded after reset (warm-up); 0 means no warm-up.
- `DEPTH`, default 8: FIFO depth in entries; power of 2, ≥2.
- `clk` in 1: clock, all state on rising edge.
- `rst_p` in 1: reset, asynchronous, active-high.
- `y_in` in 16: filter output sample, two's complement, passed through unmodified.
- `in_valid` in 1: `y_in` is a new sample this cycle.
- `m_data` out 16: FIFO head sample; meaningful only while `m_valid`=1.
- `m_valid` out 1: FIFO non-empty.
- `m_ready` in 1: consumer accepts `m_data` this cycle.
- `level` out clog2(DEPTH)+1: current FIFO occupancy, 0..DEPTH.
- `overflow` out 1: sticky; set when a kept sample was dropped.
- `clr_ovf` in 1: synchronous clear of `overflow`.

## Operation
- Reset values: state=WARMUP (RUN if `SKIP`=0), warm-up count=0, phase=0, FIFO pointers=0, `level`=0, `m_valid`=0, `overflow`=0. `m_data` is don't-care.
- **State WARMUP**
  - Each `in_valid` cycle increments the warm-up counter; the sample is discarded.
  - The cycle consuming the `SKIP`-th sample moves the block to RUN.
  - Phase stays 0 throughout WARMUP.
- **State RUN**
  - Each `in_valid` cycle: the sample is kept iff phase==0.
  - Phase then increments, wrapping from `DECIM`-1 to 0.
  - The first valid sample in RUN is always kept.
  - RUN persists until reset.
- `in_valid`=0: no state, counter or phase change.
- **Push**: a kept sample is written iff `level` < `DEPTH`, or `level`==`DEPTH` and a pop occurs in the same cycle (simultaneous pop+push at full is legal and lossless).
- **Drop**: a kept sample that cannot be written is dropped, and `overflow` is set at the next edge. Nothing already in the FIFO is overwritten.
- **Pop**: occurs when `m_valid` && `m_ready`. `m_ready` while empty has no effect.
- `level` updates per cycle:
  - +1 on push only;
  - −1 on pop only;
  - unchanged on both or neither.
- Read and write pointers wrap modulo `DEPTH`.
- `overflow`: `clr_ovf` clears it. If `clr_ovf` and a drop occur in the same cycle, set wins and `overflow` stays 1.
- Data is bit-exact: no rounding, scaling or sign change.

## Timing
- Latency: a sample kept at edge k, with the FIFO empty, gives `m_valid`=1 and `m_data`=sample after edge k. That is one clock from the `in_valid` cycle to `m_valid`.
- FWFT behaviour:
  - `m_data` is a combinational read of the head entry and changes only after a pop or after a push into an empty FIFO.
  - `m_data`/`m_valid` hold stable while `m_valid`=1 and `m_ready`=0.
- Throughput: one pop per clock sustained, one push per clock max (`DECIM`=1).
- Reset mid-operation: asserting `rst_p` immediately clears `m_valid`, `level` and `overflow` without waiting for a clock edge. The FIFO contents are lost, and WARMUP restarts with a full `SKIP` count after deassertion.

## Test plan
Bench parameters: `DECIM`=4, `SKIP`=3, `DEPTH`=4, stimulus `y_in`=1,2,3,… with `in_valid`=1 every cycle unless stated.

1. **Warm-up and decimation.** `m_ready`=1. Required response:
   - Samples 1–3 are discarded.
   - `m_data` presents 4, 8, 12, 16 in order.
   - Each value appears with `m_valid`=1 for exactly one cycle, one clock after its input cycle.
   - `level` never exceeds 1.
2. **Input gaps.** `in_valid` toggles 1/0 after warm-up. Required response: the kept values are still 4, 8, 12; phase does not advance on `in_valid`=0 cycles.
3. **Overflow.** `m_ready`=0, feed 1..20. Required response:
   - `level`=4 after 16 is kept.
   - 20 is dropped and `overflow`=1.
   - Draining with `m_ready`=1 yields exactly 4, 8, 12, 16, then `m_valid`=0.
4. **Push and pop at full.** `level`=4 with `m_ready`=1 in the cycle 20 is kept. Required response:
   - Pop of 4 and push of 20 happen in the same cycle.
   - `level` stays 4 and `overflow` stays 0.
   - A subsequent drain yields 8, 12, 16, 20.
5. **Overflow clear.** Required response: `clr_ovf` coinciding with a drop leaves `overflow`=1; `clr_ovf` alone on the next cycle gives `overflow`=0.
6. **Reset mid-stream.** Assert `rst_p` between clock edges with `level`=3. Required response:
   - `m_valid`=0, `level`=0 and `overflow`=0 before the next clock edge.
   - After release, with inputs 100, 101, …, the first output is 103.
